// File: rtl/cpu_bus_pkg.sv
// Shared sram-like bus definitions: transfer size encodings and the channel-ID width helper.
package cpu_bus_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // A single channel still needs a one-bit ID so the FIFO never collapses to zero width.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_like_arb_if.sv
// Bundles the N requester ports and the single downstream sram-like port of the arbiter.
interface sram_like_arb_if #(
  parameter int NCH = 2
);

  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_wr;
  logic [2*NCH-1:0]  ch_size;
  logic [32*NCH-1:0] ch_addr;
  logic [4*NCH-1:0]  ch_wstrb;
  logic [32*NCH-1:0] ch_wdata;
  logic [NCH-1:0]    ch_addr_ok;
  logic [NCH-1:0]    ch_data_ok;
  logic [31:0]       ch_rdata;

  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [31:0]       mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [31:0]       mem_rdata;

  logic              err_unexp;

  // Environment view: requesters plus downstream memory.
  modport master (
    output ch_req, ch_wr, ch_size, ch_addr, ch_wstrb, ch_wdata,
    input  ch_addr_ok, ch_data_ok, ch_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  err_unexp
  );

  // Arbiter view.
  modport slave (
    input  ch_req, ch_wr, ch_size, ch_addr, ch_wstrb, ch_wdata,
    output ch_addr_ok, ch_data_ok, ch_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output err_unexp
  );

endinterface

// File: rtl/sram_like_arb_fifo.sv
// Pointer-based synchronous FIFO; the extra wrap bit on each pointer separates full from empty.
module sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count = wr_ptr_r - rd_ptr_r;
  assign dout  = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer advance; reset discards every stored entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Entry storage, no reset needed since validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/sram_like_arb.sv
// N-channel sram-like arbiter: merges requesters onto one downstream port and routes
// in-order responses back to the issuing channel through an ID FIFO.
module sram_like_arb
  import cpu_bus_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 4,
  parameter int RR    = 0
) (
  input logic            clk,
  input logic            reset,
  sram_like_arb_if.slave bus
);

  localparam int ID_W = id_width(NCH);
  localparam int CW   = $clog2(DEPTH) + 1;

  logic [ID_W-1:0] grant_s;
  logic [ID_W-1:0] lock_id_r;
  logic [ID_W-1:0] rr_ptr_r;
  logic [ID_W-1:0] rr_next_s;
  logic [ID_W-1:0] head_s;
  logic            found_s;
  logic            locked_r;
  logic            err_unexp_r;
  logic            any_req_s;
  logic            mem_req_s;
  logic            accept_s;
  logic            pop_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [CW-1:0]   fifo_count_s;

  // Winner selection; a held (locked) request always keeps the grant.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    if (locked_r) begin
      grant_s = lock_id_r;
    end else if (RR == 0) begin
      for (int i = 0; i < NCH; i++) begin
        grant_s = bus.ch_req[i] ? ID_W'(i) : grant_s;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        grant_s = (!found_s && bus.ch_req[(int'(rr_ptr_r) + k) % NCH])
                  ? ID_W'((int'(rr_ptr_r) + k) % NCH) : grant_s;
        found_s = found_s | bus.ch_req[(int'(rr_ptr_r) + k) % NCH];
      end
    end
  end

  assign any_req_s = |bus.ch_req;
  assign mem_req_s = (any_req_s | locked_r) & ~fifo_full_s & ~reset;
  assign accept_s  = mem_req_s & bus.mem_addr_ok;
  // Head is the FIFO's registered content, so a same-cycle accept is never answered.
  assign pop_s     = bus.mem_data_ok & ~fifo_empty_s & ~reset;
  assign rr_next_s = (grant_s == ID_W'(NCH - 1)) ? '0 : grant_s + ID_W'(1);

  assign bus.mem_req   = mem_req_s;
  assign bus.mem_wr    = bus.ch_wr[grant_s];
  assign bus.mem_size  = bus.ch_size[2*int'(grant_s) +: 2];
  assign bus.mem_addr  = bus.ch_addr[32*int'(grant_s) +: 32];
  assign bus.mem_wstrb = bus.ch_wstrb[4*int'(grant_s) +: 4];
  assign bus.mem_wdata = bus.ch_wdata[32*int'(grant_s) +: 32];
  assign bus.ch_rdata  = bus.mem_rdata;
  assign bus.err_unexp = err_unexp_r;

  // One-hot handshake fan-out to the granted and the head channels.
  always_comb begin
    bus.ch_addr_ok = '0;
    bus.ch_data_ok = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.ch_addr_ok[i] = accept_s && (grant_s == ID_W'(i));
      bus.ch_data_ok[i] = pop_s && (head_s == ID_W'(i));
    end
  end

  sync_fifo #(
    .WIDTH (ID_W),
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept_s),
    .pop   (pop_s),
    .din   (grant_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Lock tracking: a stalled request keeps its channel until the memory accepts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_r  <= 1'b0;
      lock_id_r <= '0;
    end else if (accept_s) begin
      locked_r  <= 1'b0;
    end else if (mem_req_s) begin
      locked_r  <= 1'b1;
      lock_id_r <= grant_s;
    end else begin
      locked_r  <= locked_r;
    end
  end

  // Round-robin pointer moves past the channel that was just served.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r <= '0;
    end else if (accept_s && (RR != 0)) begin
      rr_ptr_r <= rr_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Sticky flag for a response arriving with no outstanding transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_unexp_r <= 1'b0;
    end else if (bus.mem_data_ok && (fifo_count_s == CW'(0))) begin
      err_unexp_r <= 1'b1;
    end else begin
      err_unexp_r <= err_unexp_r;
    end
  end

endmodule

// File: tb/tb_sram_like_arb.sv
// Bench for sram_like_arb: directed scenarios plus random traffic against a queue-based reference.
module tb_sram_like_arb;
  import cpu_bus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_like_arb_if #(.NCH(2)) ifa ();
  sram_like_arb_if #(.NCH(3)) ifb ();

  sram_like_arb #(.NCH(2), .DEPTH(4), .RR(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  sram_like_arb #(.NCH(3), .DEPTH(4), .RR(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  logic [2:0]  req, wr;
  logic [5:0]  size;
  logic [95:0] addr, wdata;
  logic [11:0] wstrb;
  logic        maok, mdok;
  logic [31:0] mrdata;

  assign ifa.ch_req = req[1:0];      assign ifb.ch_req = req;
  assign ifa.ch_wr = wr[1:0];        assign ifb.ch_wr = wr;
  assign ifa.ch_size = size[3:0];    assign ifb.ch_size = size;
  assign ifa.ch_addr = addr[63:0];   assign ifb.ch_addr = addr;
  assign ifa.ch_wstrb = wstrb[7:0];  assign ifb.ch_wstrb = wstrb;
  assign ifa.ch_wdata = wdata[63:0]; assign ifb.ch_wdata = wdata;
  assign ifa.mem_addr_ok = maok;     assign ifb.mem_addr_ok = maok;
  assign ifa.mem_data_ok = mdok;     assign ifb.mem_data_ok = mdok;
  assign ifa.mem_rdata = mrdata;     assign ifb.mem_rdata = mrdata;

  int          sel;
  logic        o_mreq, o_mwr, o_err;
  logic [1:0]  o_msize;
  logic [3:0]  o_mwstrb;
  logic [31:0] o_maddr, o_mwdata, o_rdata;
  logic [2:0]  o_aok, o_dok;

  always_comb begin
    if (sel == 0) begin
      o_mreq = ifa.mem_req; o_mwr = ifa.mem_wr; o_msize = ifa.mem_size; o_maddr = ifa.mem_addr;
      o_mwstrb = ifa.mem_wstrb; o_mwdata = ifa.mem_wdata; o_rdata = ifa.ch_rdata; o_err = ifa.err_unexp;
      o_aok = {1'b0, ifa.ch_addr_ok}; o_dok = {1'b0, ifa.ch_data_ok};
    end else begin
      o_mreq = ifb.mem_req; o_mwr = ifb.mem_wr; o_msize = ifb.mem_size; o_maddr = ifb.mem_addr;
      o_mwstrb = ifb.mem_wstrb; o_mwdata = ifb.mem_wdata; o_rdata = ifb.ch_rdata; o_err = ifb.err_unexp;
      o_aok = ifb.ch_addr_ok; o_dok = ifb.ch_data_ok;
    end
  end

  // Reference model: outstanding channel IDs in issue order, plus lock / pointer / error state.
  int   q[$];
  bit   m_locked, m_err;
  int   m_lock_id, m_rr;
  int   nch, rrm;
  int   depth = 4;
  bit   e_mreq, e_acc, e_pop;
  int   e_g;
  logic [2:0] e_aok, e_dok;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int arb();
    if (m_locked) return m_lock_id;
    if (rrm == 0) begin
      for (int i = nch - 1; i >= 0; i--) begin
        if (req[i]) return i;
      end
    end else begin
      for (int k = 0; k < nch; k++) begin
        if (req[(m_rr + k) % nch]) return (m_rr + k) % nch;
      end
    end
    return 0;
  endfunction

  task automatic settle_check();
    bit anyr;
    #1;
    anyr = 1'b0;
    for (int i = 0; i < nch; i++) anyr = anyr | req[i];
    e_g    = arb();
    e_mreq = (anyr || m_locked) && (q.size() < depth) && !reset;
    e_acc  = e_mreq && maok;
    e_pop  = mdok && (q.size() > 0) && !reset;
    e_aok  = 3'b000;
    e_dok  = 3'b000;
    if (e_acc) e_aok[e_g] = 1'b1;
    if (e_pop) e_dok[q[0]] = 1'b1;
    chk("mem_req", {31'd0, o_mreq}, {31'd0, e_mreq});
    chk("ch_addr_ok", {29'd0, o_aok}, {29'd0, e_aok});
    chk("ch_data_ok", {29'd0, o_dok}, {29'd0, e_dok});
    chk("err_unexp", {31'd0, o_err}, {31'd0, m_err});
    if (e_mreq) begin
      chk("mem_addr", o_maddr, addr[32*e_g +: 32]);
      chk("mem_wr", {31'd0, o_mwr}, {31'd0, wr[e_g]});
      chk("mem_size", {30'd0, o_msize}, {30'd0, size[2*e_g +: 2]});
      chk("mem_wstrb", {28'd0, o_mwstrb}, {28'd0, wstrb[4*e_g +: 4]});
      chk("mem_wdata", o_mwdata, wdata[32*e_g +: 32]);
    end
    if (e_pop) chk("ch_rdata", o_rdata, mrdata);
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_locked = 1'b0; m_lock_id = 0; m_rr = 0; m_err = 1'b0;
    end else begin
      if (mdok && q.size() == 0) m_err = 1'b1;
      if (e_pop) void'(q.pop_front());
      if (e_acc) begin
        q.push_back(e_g);
        m_locked = 1'b0;
        if (rrm != 0) m_rr = (e_g + 1) % nch;
      end else if (e_mreq) begin
        m_locked = 1'b1;
        m_lock_id = e_g;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle_check();
    advance();
  endtask

  task automatic idle();
    req = 3'b000; wr = 3'b000; size = 6'd0; addr = 96'd0; wstrb = 12'd0; wdata = 96'd0;
    maok = 1'b0; mdok = 1'b0; mrdata = 32'd0;
  endtask

  task automatic set_ch(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req[i] = 1'b1;
    wr[i] = w;
    size[2*i +: 2] = SIZE_W;
    addr[32*i +: 32] = a;
    wstrb[4*i +: 4] = w ? 4'hf : 4'h0;
    wdata[32*i +: 32] = d;
  endtask

  task automatic start(input int s, input int n, input int r);
    sel = s; nch = n; rrm = r;
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic rand_phase(input int s, input int n, input int r, input int cycles);
    logic [2:0] pend;
    start(s, n, r);
    pend = 3'b000;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < n; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1'b1;
          set_ch(i, 1'($urandom_range(1, 0)), $urandom, $urandom);
          size[2*i +: 2] = 2'($urandom_range(2, 0));
          wstrb[4*i +: 4] = 4'($urandom);
        end
        req[i] = pend[i];
      end
      maok   = ($urandom_range(9, 0) < 7);
      mdok   = (q.size() > 0) ? 1'($urandom_range(1, 0)) : ($urandom_range(29, 0) == 0);
      mrdata = $urandom;
      reset  = ($urandom_range(149, 0) == 0);
      settle_check();
      for (int i = 0; i < n; i++) if (e_aok[i]) pend[i] = 1'b0;
      advance();
    end
    reset = 1'b0;
  endtask

  initial begin
    sel = 0; nch = 2; rrm = 0;
    idle();
    reset = 1'b1;
    m_locked = 1'b0; m_err = 1'b0; m_lock_id = 0; m_rr = 0;
    @(posedge clk);
    @(negedge clk);

    // Reset state on the fixed-priority instance.
    start(0, 2, 0);
    set_ch(1, 1'b0, 32'h1c00_0000, 32'd0);
    reset = 1'b1; maok = 1'b1;
    settle_check();
    chk("rst_mem_req", {31'd0, o_mreq}, 32'd0);
    advance();
    reset = 1'b0; idle();
    settle_check();
    chk("rst_err", {31'd0, o_err}, 32'd0);
    advance();

    // Single read, response one cycle after acceptance.
    set_ch(1, 1'b0, 32'h1c00_0000, 32'd0);
    maok = 1'b1;
    settle_check();
    chk("t1_addr_ok", {29'd0, o_aok}, 32'd2);
    chk("t1_mem_addr", o_maddr, 32'h1c00_0000);
    advance();
    idle(); mdok = 1'b1; mrdata = 32'hdead_beef;
    settle_check();
    chk("t1_data_ok", {29'd0, o_dok}, 32'd2);
    chk("t1_rdata", o_rdata, 32'hdead_beef);
    advance();
    idle();

    // Lock: channel 0 stalls three cycles while channel 1 joins.
    set_ch(0, 1'b1, 32'h0000_1000, 32'h1111_2222);
    settle_check();
    chk("t2_first", o_maddr, 32'h0000_1000);
    advance();
    set_ch(1, 1'b0, 32'h0000_2000, 32'd0);
    for (int c = 0; c < 2; c++) begin
      settle_check();
      chk("t2_hold_addr", o_maddr, 32'h0000_1000);
      chk("t2_hold_aok", {29'd0, o_aok}, 32'd0);
      advance();
    end
    maok = 1'b1;
    settle_check();
    chk("t2_acc0", {29'd0, o_aok}, 32'd1);
    chk("t2_acc0_addr", o_maddr, 32'h0000_1000);
    advance();
    req[0] = 1'b0;
    settle_check();
    chk("t2_acc1", {29'd0, o_aok}, 32'd2);
    chk("t2_acc1_addr", o_maddr, 32'h0000_2000);
    advance();
    idle(); mdok = 1'b1;
    settle_check();
    chk("t2_resp0", {29'd0, o_dok}, 32'd1);
    advance();
    settle_check();
    chk("t2_resp1", {29'd0, o_dok}, 32'd2);
    advance();
    idle();

    // Full: four acceptances fill the FIFO, one response reopens it next cycle.
    set_ch(1, 1'b0, 32'h0000_3000, 32'd0);
    maok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle_check();
      chk("t3_fill", {29'd0, o_aok}, 32'd2);
      advance();
    end
    settle_check();
    chk("t3_full", {31'd0, o_mreq}, 32'd0);
    advance();
    mdok = 1'b1; mrdata = 32'h0bad_cafe;
    settle_check();
    chk("t3_full_pop", {31'd0, o_mreq}, 32'd0);
    chk("t3_pop_dok", {29'd0, o_dok}, 32'd2);
    advance();
    mdok = 1'b0;
    settle_check();
    chk("t3_reopen", {31'd0, o_mreq}, 32'd1);
    advance();
    idle(); mdok = 1'b1;
    repeat (4) step();
    idle();

    // Unexpected response with nothing outstanding.
    mdok = 1'b1;
    settle_check();
    chk("t4_no_dok", {29'd0, o_dok}, 32'd0);
    advance();
    mdok = 1'b0;
    repeat (3) begin
      settle_check();
      chk("t4_sticky", {31'd0, o_err}, 32'd1);
      advance();
    end
    start(0, 2, 0);
    settle_check();
    chk("t4_cleared", {31'd0, o_err}, 32'd0);
    advance();

    // Reset with two requests in flight; later responses are unexpected.
    set_ch(1, 1'b0, 32'h0000_5000, 32'd0);
    maok = 1'b1;
    step();
    step();
    idle(); reset = 1'b1; mdok = 1'b1;
    settle_check();
    chk("t5_rst_dok", {29'd0, o_dok}, 32'd0);
    chk("t5_rst_mreq", {31'd0, o_mreq}, 32'd0);
    advance();
    reset = 1'b0;
    repeat (2) begin
      settle_check();
      chk("t5_no_dok", {29'd0, o_dok}, 32'd0);
      advance();
    end
    mdok = 1'b0;
    settle_check();
    chk("t5_err", {31'd0, o_err}, 32'd1);
    advance();

    // Round-robin ordering on the three-channel instance.
    start(1, 3, 1);
    for (int i = 0; i < 3; i++) set_ch(i, 1'b0, 32'h0000_4000 + 32'(i * 16), 32'd0);
    maok = 1'b1;
    for (int c = 0; c < 9; c++) begin
      logic [2:0] g_exp, r_exp;
      g_exp = 3'b000; g_exp[c % 3] = 1'b1;
      r_exp = 3'b000;
      if (c > 0) r_exp[(c - 1) % 3] = 1'b1;
      mrdata = $urandom;
      settle_check();
      chk("ord_grant", {29'd0, o_aok}, {29'd0, g_exp});
      chk("ord_resp", {29'd0, o_dok}, {29'd0, r_exp});
      advance();
      mdok = 1'b1;
    end
    idle(); mdok = 1'b1;
    step();
    idle();

    rand_phase(0, 2, 0, 400);
    rand_phase(1, 3, 1, 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
